// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake and single-port RAM bundle for mem_access_unit.
interface mem_access_unit_if #(parameter int ADDR_W = 10);
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic mem_we, mem_regce;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    input req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_din, mem_we, mem_regce
  );
  modport slave (
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_din, mem_we, mem_regce
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store requester with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 1024,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W = $clog2(RAM_DEPTH)
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, next;
  logic we_q, uns_q, err_q;
  logic [1:0] size_q, cnt;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0] wdata_q, shifted, ext, mask, merged;
  logic [RAM_WIDTH-1:0] word_q;
  logic [4:0] sh;
  logic accept, err_in, last_rd;
  assign accept = bus.req_valid & bus.req_ready;
  assign err_in = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                  (bus.req_size == 2'b10 && |bus.req_addr[1:0]) || bus.req_addr[31:2] >= 30'(RAM_DEPTH);
  assign last_rd = state == READ && cnt == 2'(READ_LATENCY - 1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = !accept ? IDLE : err_in ? RESP : (bus.req_we && bus.req_size == 2'b10) ? WRITE : READ;
      READ:  next = !last_rd ? READ : we_q ? WRITE : RESP;
      WRITE: next = RESP;
      RESP:  next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      we_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b0;
      addr_q <= '0;
      wdata_q <= 32'b0;
      word_q <= '0;
      cnt <= 2'b0;
    end else begin
      if (accept) begin
        we_q <= bus.req_we;
        uns_q <= bus.req_unsigned;
        err_q <= err_in;
        size_q <= bus.req_size;
        addr_q <= bus.req_addr[ADDR_W+1:0];
        wdata_q <= bus.req_wdata;
      end
      cnt <= (state == READ && !last_rd) ? cnt + 2'd1 : 2'd0;
      if (last_rd) word_q <= bus.mem_dout;
    end
  // Lane shift and mask drive both load extraction and the store merge.
  always_comb begin
    sh = {addr_q[1:0], 3'b000};
    shifted = word_q >> sh;
    ext = size_q == 2'b10 ? word_q :
          size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} :
                            {{24{~uns_q & shifted[7]}}, shifted[7:0]};
    mask = size_q == 2'b00 ? 32'h0000_00ff : size_q == 2'b01 ? 32'h0000_ffff : 32'hffff_ffff;
    merged = (word_q & ~(mask << sh)) | ((wdata_q & mask) << sh);
  end
  always_comb begin
    bus.req_ready = state == IDLE && !rst;
    bus.resp_valid = state == RESP && !rst;
    bus.resp_err = state == RESP && !rst && err_q;
    bus.resp_rdata = (state == RESP && !we_q && !err_q) ? ext : 32'b0;
    bus.mem_addr = addr_q[ADDR_W+1:2];
    bus.mem_we = state == WRITE && !rst;
    bus.mem_regce = state == READ;
    bus.mem_din = state == WRITE ? merged : 32'b0;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives READ_LATENCY=1 and =2 instances with identical requests against a byte-level memory model.
module tb_mem_access_unit;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  typedef struct {
    logic we;
    logic [1:0] sz;
    logic uns;
    logic [31:0] addr, wd;
    logic err;
    logic [31:0] rd;
  } vec_t;
  logic clk = 0, rst = 1, clr = 1;
  logic rv = 0, rwe = 0, runs = 0;
  logic [1:0] rsz = 0;
  logic [31:0] raddr = 0, rwd = 0, d2;
  logic [31:0] ram1[DEPTH], ram2[DEPTH], mdl[DEPTH];
  int cyc = 0, checks = 0, errors = 0;
  int rc[2], rcy[2], we_n[2], we_at[2], rg_n[2], rdy_bad[2], adr_bad[2];
  logic [31:0] rd[2];
  logic er[2];
  vec_t tv[25];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_access_unit_if #(.ADDR_W(AW)) b1();
  mem_access_unit_if #(.ADDR_W(AW)) b2();
  assign b1.req_valid = rv;
  assign b1.req_we = rwe;
  assign b1.req_size = rsz;
  assign b1.req_unsigned = runs;
  assign b1.req_addr = raddr;
  assign b1.req_wdata = rwd;
  assign b2.req_valid = rv;
  assign b2.req_we = rwe;
  assign b2.req_size = rsz;
  assign b2.req_unsigned = runs;
  assign b2.req_addr = raddr;
  assign b2.req_wdata = rwd;
  assign b1.mem_dout = ram1[b1.mem_addr];
  assign b2.mem_dout = d2;
  mem_access_unit #(.READ_LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_access_unit #(.READ_LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  // RAM models: latency 1 reads combinationally, latency 2 adds an output register gated by regce.
  always @(posedge clk)
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram1[i] <= 0;
        ram2[i] <= 0;
      end
      d2 <= 0;
    end else begin
      if (b1.mem_we) ram1[b1.mem_addr] <= b1.mem_din;
      if (b2.mem_we) ram2[b2.mem_addr] <= b2.mem_din;
      if (b2.mem_regce) d2 <= ram2[b2.mem_addr];
    end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic is_err(input logic [1:0] s, input logic [31:0] a);
    return s == 3 || (s == 1 && a[0]) || (s == 2 && a[1:0] != 0) || a[31:2] >= DEPTH;
  endfunction
  function automatic int lat_of(input int l, input logic we, input logic [1:0] s, input logic e);
    return e ? 1 : (we && s == 2) ? 2 : we ? 2 + l : 1 + l;
  endfunction
  function automatic logic [31:0] mload(input logic [1:0] s, input logic uns, input logic [31:0] a);
    int n = 1 << s;
    int k = int'(a[1:0]);
    logic [31:0] v = 0;
    logic [31:0] w = mdl[a[AW+1:2]];
    for (int b = 0; b < n; b++) v[8*b+:8] = w[8*(k+b)+:8];
    if (!uns && n < 4 && v[8*n-1]) for (int b = n; b < 4; b++) v[8*b+:8] = 8'hff;
    return v;
  endfunction
  task automatic mstore(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd);
    int n = 1 << s;
    int k = int'(a[1:0]);
    for (int b = 0; b < n; b++) mdl[a[AW+1:2]][8*(k+b)+:8] = wd[8*b+:8];
  endtask
  task automatic smp(input int j, input int i, input int lat, input logic chk_adr, input logic [AW-1:0] wa,
                     input logic v, input logic rdy, input logic e, input logic [31:0] d,
                     input logic we, input logic rg, input logic [AW-1:0] ma);
    if (v) begin
      rc[j]++;
      rcy[j] = i;
      rd[j] = d;
      er[j] = e;
    end
    if (we) begin
      we_n[j]++;
      we_at[j] = i;
    end
    if (rg) rg_n[j]++;
    if (rdy !== (i > lat)) rdy_bad[j]++;
    if (chk_adr && i <= lat && ma !== wa) adr_bad[j]++;
  endtask
  task automatic do_req(input logic we, input logic [1:0] s, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic e, input logic [31:0] d, input string nm);
    int lat[2];
    int imax, n;
    logic [AW-1:0] wa;
    wa = a[AW+1:2];
    lat[0] = lat_of(1, we, s, e);
    lat[1] = lat_of(2, we, s, e);
    imax = (lat[1] > lat[0] ? lat[1] : lat[0]) + 1;
    for (int j = 0; j < 2; j++) begin
      rc[j] = 0; rcy[j] = 0; we_n[j] = 0; we_at[j] = 0; rg_n[j] = 0;
      rdy_bad[j] = 0; adr_bad[j] = 0; rd[j] = 0; er[j] = 0;
    end
    n = 0;
    @(negedge clk);
    while (!(b1.req_ready && b2.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({nm, " ready_wait"}, 0, 1);
    rv = 1; rwe = we; rsz = s; runs = uns; raddr = a; rwd = wd;
    for (int i = 1; i <= imax; i++) begin
      @(negedge clk);
      smp(0, i, lat[0], !e, wa, b1.resp_valid, b1.req_ready, b1.resp_err, b1.resp_rdata, b1.mem_we, b1.mem_regce, b1.mem_addr);
      smp(1, i, lat[1], !e, wa, b2.resp_valid, b2.req_ready, b2.resp_err, b2.resp_rdata, b2.mem_we, b2.mem_regce, b2.mem_addr);
      rv = i < lat[0];
      rwe = 1'($urandom); rsz = 2'($urandom); runs = 1'($urandom); raddr = $urandom; rwd = $urandom;
    end
    if (we && !e) mstore(s, a, wd);
    for (int j = 0; j < 2; j++) begin
      string p = $sformatf("%s L%0d", nm, j + 1);
      chk({p, " resp_count"}, rc[j], 1);
      chk({p, " resp_cycle"}, rcy[j], lat[j]);
      chk({p, " resp_err"}, er[j], e);
      chk({p, " resp_rdata"}, rd[j], d);
      chk({p, " we_count"}, we_n[j], (we && !e) ? 1 : 0);
      if (we && !e) chk({p, " we_cycle"}, we_at[j], lat[j] - 1);
      chk({p, " regce_count"}, rg_n[j], (!e && !(we && s == 2)) ? j + 1 : 0);
      chk({p, " ready_bad"}, rdy_bad[j], 0);
      chk({p, " addr_bad"}, adr_bad[j], 0);
    end
    chk({nm, " ram1"}, ram1[wa], mdl[wa]);
    chk({nm, " ram2"}, ram2[wa], mdl[wa]);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  initial begin
    int nv;
    logic we, uns, e;
    logic [1:0] s;
    logic [31:0] a, wd, d, idx, off;
    tv[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hdeadbeef, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hdeadbeef};
    tv[2]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0};
    tv[3]  = '{1'b1, 2'd0, 1'b0, 32'h22, 32'h123456aa, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 1'b0, 32'hffffffaa};
    tv[5]  = '{1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 1'b0, 32'h000000aa};
    tv[6]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11aa3344};
    tv[7]  = '{1'b1, 2'd1, 1'b0, 32'h32, 32'hcafe8001, 1'b0, 32'h0};
    tv[8]  = '{1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1'b0, 32'hffff8001};
    tv[9]  = '{1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1'b0, 32'h00008001};
    tv[10] = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0, 32'h80010000};
    tv[11] = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0};
    tv[12] = '{1'b0, 2'd1, 1'b0, 32'h5, 32'h0, 1'b1, 32'h0};
    tv[13] = '{1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 1'b1, 32'h0};
    tv[14] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0};
    tv[15] = '{1'b1, 2'd2, 1'b0, 32'hffc, 32'h5a5a1234, 1'b0, 32'h0};
    tv[16] = '{1'b0, 2'd2, 1'b0, 32'hffc, 32'h0, 1'b0, 32'h5a5a1234};
    tv[17] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'h0badf00d, 1'b1, 32'h0};
    tv[18] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000de};
    tv[19] = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 32'hffffffbe};
    tv[20] = '{1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0, 1'b1, 32'h0};
    tv[21] = '{1'b1, 2'd1, 1'b0, 32'h1002, 32'h0000ffff, 1'b1, 32'h0};
    tv[22] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, 32'hffffdead};
    tv[23] = '{1'b1, 2'd0, 1'b0, 32'hfff, 32'h0000007f, 1'b0, 32'h0};
    tv[24] = '{1'b0, 2'd0, 1'b0, 32'hfff, 32'h0, 1'b0, 32'h0000007f};
    for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst req_ready", {b2.req_ready, b1.req_ready}, 0);
    chk("rst resp_valid", {b2.resp_valid, b1.resp_valid}, 0);
    chk("rst resp_err", {b2.resp_err, b1.resp_err}, 0);
    chk("rst resp_rdata", b1.resp_rdata | b2.resp_rdata, 0);
    chk("rst mem_addr", 32'(b1.mem_addr | b2.mem_addr), 0);
    chk("rst mem_din", b1.mem_din | b2.mem_din, 0);
    chk("rst mem_we_regce", {b2.mem_we, b2.mem_regce, b1.mem_we, b1.mem_regce}, 0);
    rst = 0;
    clr = 0;
    #1;
    chk("rst release ready", {b2.req_ready, b1.req_ready}, 2'b11);
    for (int i = 0; i < 25; i++)
      do_req(tv[i].we, tv[i].sz, tv[i].uns, tv[i].addr, tv[i].wd, tv[i].err, tv[i].rd, $sformatf("v%0d", i));
    // Reset lands on the WRITE cycle of the latency-1 byte store.
    @(negedge clk);
    rv = 1; rwe = 1; rsz = 0; runs = 0; raddr = 32'h21; rwd = 32'h77;
    @(negedge clk);
    rv = 0;
    @(negedge clk);
    chk("abort we_before_rst", b1.mem_we, 1);
    rst = 1;
    #1;
    chk("abort we_gated", b1.mem_we, 0);
    chk("abort ready_in_rst", {b2.req_ready, b1.req_ready}, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort ready_after", {b2.req_ready, b1.req_ready}, 2'b11);
    nv = 0;
    repeat (5) begin
      if (b1.resp_valid || b2.resp_valid) nv++;
      @(negedge clk);
    end
    chk("abort no_resp", nv, 0);
    chk("abort ram1", ram1[8], mdl[8]);
    chk("abort ram2", ram2[8], mdl[8]);
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom);
      uns = 1'($urandom);
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0: idx = DEPTH + $urandom_range(0, 3);
        1: idx = DEPTH - 1;
        default: idx = $urandom_range(0, 15);
      endcase
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) off = (s == 1) ? (off & 2) : (s == 2) ? 0 : off;
      a = (idx << 2) | off;
      wd = $urandom;
      e = is_err(s, a);
      d = (we || e) ? 32'h0 : mload(s, uns, a);
      do_req(we, s, uns, a, wd, e, d, $sformatf("rnd%0d", t));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
